// File: rtl/map_color_search_pkg.sv
// map_color_search_pkg
// Shared definitions for the Land of Oz coloring search:
//   - bit offsets of each region's 2-bit color inside the packed 'sol' word
//   - FSM state encoding used by the search controller
//   - candidate and solution counts for the full and symmetric searches
package map_color_search_pkg;

  localparam int COLOR_W = 2;
  localparam int SOL_W   = 10;
  localparam int COUNT_W = 11;

  // Packed coloring layout: {GC, WC, QC, MC, EC}, EC in the LSBs
  localparam int EC_LSB = 0;
  localparam int MC_LSB = 2;
  localparam int QC_LSB = 4;
  localparam int WC_LSB = 6;
  localparam int GC_LSB = 8;

  localparam int NUM_CAND_FULL = 1024;
  localparam int NUM_CAND_SYM  = 256;
  localparam int NUM_SOL_FULL  = 72;
  localparam int NUM_SOL_SYM   = 18;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD,
    DONE
  } state_t;

endpackage

// File: rtl/oz_adjacency_check.sv
// oz_adjacency_check
// Purely combinational validity test for one coloring of the five regions.
// Ports:
//   gc, wc, qc, mc, ec : 2-bit colors of each region
//   valid              : 1 when every pair of neighbouring regions differs
module oz_adjacency_check (
  input  logic [1:0] gc,
  input  logic [1:0] wc,
  input  logic [1:0] qc,
  input  logic [1:0] mc,
  input  logic [1:0] ec,
  output logic       valid
);

  // The outer four regions form a ring (GC-WC-QC-MC-GC) and EC touches all
  // of them, so eight inequalities cover every shared border.
  always_comb begin
    valid = (gc != wc) && (wc != qc) && (qc != mc) && (mc != gc) &&
            (ec != gc) && (ec != wc) && (ec != qc) && (ec != mc);
  end

endmodule

// File: rtl/map_color_search.sv
// map_color_search
// Walks every candidate coloring one per clock, streams each valid one out
// over a valid/ready handshake and reports the total solution count.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   start      : one-cycle request to begin a scan (ignored unless idle)
//   busy       : high from the cycle after start through the done cycle
//   done       : one-cycle pulse at the end of a scan
//   sol_valid  : a valid coloring is presented on sol
//   sol_ready  : consumer accepts sol when sol_valid && sol_ready
//   sol        : packed coloring {GC, WC, QC, MC, EC}
//   count      : number of solutions found in the current or last scan
module map_color_search
  import map_color_search_pkg::*;
#(
  parameter bit SKIP_SYMMETRIC = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               sol_valid,
  input  logic               sol_ready,
  output logic [SOL_W-1:0]   sol,
  output logic [COUNT_W-1:0] count
);

  state_t           state;
  logic [SOL_W-1:0] cand;
  logic [SOL_W-1:0] cand_eff;
  logic             cand_last;
  logic             cand_valid;

  // In the symmetric search GC is pinned to color 0, so only the lower
  // eight counter bits matter and the scan ends at 0x0FF.
  always_comb begin
    cand_eff  = cand;
    cand_last = (cand == 10'h3FF);
    if (SKIP_SYMMETRIC) begin
      cand_eff  = {2'b00, cand[7:0]};
      cand_last = (cand[7:0] == 8'hFF);
    end
  end

  oz_adjacency_check u_check (
    .gc    (cand_eff[GC_LSB +: COLOR_W]),
    .wc    (cand_eff[WC_LSB +: COLOR_W]),
    .qc    (cand_eff[QC_LSB +: COLOR_W]),
    .mc    (cand_eff[MC_LSB +: COLOR_W]),
    .ec    (cand_eff[EC_LSB +: COLOR_W]),
    .valid (cand_valid)
  );

  // Search controller. All outputs are registered here so sol cannot glitch
  // while sol_valid is high; it only changes when a new solution is loaded
  // in SCAN, which can only happen after the previous one was accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cand      <= '0;
      count     <= '0;
      sol       <= '0;
      sol_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            cand  <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end

        SCAN: begin
          if (cand_valid) begin
            sol       <= cand_eff;
            sol_valid <= 1'b1;
            count     <= count + 11'd1;
            state     <= HOLD;
          end else if (cand_last) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cand <= cand + 10'd1;
          end
        end

        // The counter is advanced only after the handshake, so a stalled
        // consumer freezes the scan without losing its place.
        HOLD: begin
          if (sol_ready) begin
            sol_valid <= 1'b0;
            if (cand_last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              cand  <= cand + 10'd1;
              state <= SCAN;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_map_color_search.sv
// tb_map_color_search
// Self-checking bench for map_color_search. Two instances are built, one
// full search and one symmetric search, sharing the same stimulus. A table
// of scenarios drives scans with ready tied high, random backpressure and
// stray start pulses; a hand-written sequence resets the design in HOLD.
// Every streamed coloring is compared against a list built directly from
// the eight map-coloring inequalities.
module tb_map_color_search;
  import map_color_search_pkg::*;

  typedef struct {
    string      name;
    bit         sym;
    int         ready_mode;
    bit         pulses;
    int         exp_count;
    int         exp_done;
    logic [9:0] exp_first;
    logic [9:0] exp_last;
  } vec_t;

  localparam int BUDGET = 6000;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic sol_ready;

  logic        busy_f, done_f, sv_f;
  logic [9:0]  sol_f;
  logic [10:0] count_f;
  logic        busy_s, done_s, sv_s;
  logic [9:0]  sol_s;
  logic [10:0] count_s;

  bit          sel_sym;
  logic        m_busy, m_done, m_sv;
  logic [9:0]  m_sol;
  logic [10:0] m_count;

  int errors = 0;
  int checks = 0;

  logic [9:0] ref_full[$];
  logic [9:0] ref_sym[$];
  logic [9:0] got_q[$];

  vec_t vecs[5];

  always #5 clk = ~clk;

  map_color_search #(.SKIP_SYMMETRIC(1'b0)) dut_f (
    .clk(clk), .rst(rst), .start(start), .busy(busy_f), .done(done_f),
    .sol_valid(sv_f), .sol_ready(sol_ready), .sol(sol_f), .count(count_f)
  );

  map_color_search #(.SKIP_SYMMETRIC(1'b1)) dut_s (
    .clk(clk), .rst(rst), .start(start), .busy(busy_s), .done(done_s),
    .sol_valid(sv_s), .sol_ready(sol_ready), .sol(sol_s), .count(count_s)
  );

  // Observe whichever instance the current scenario is about
  assign m_busy  = sel_sym ? busy_s  : busy_f;
  assign m_done  = sel_sym ? done_s  : done_f;
  assign m_sv    = sel_sym ? sv_s    : sv_f;
  assign m_sol   = sel_sym ? sol_s   : sol_f;
  assign m_count = sel_sym ? count_s : count_f;

  function automatic bit model_valid(input logic [9:0] c);
    logic [1:0] g, w, q, m, e;
    g = c[9:8]; w = c[7:6]; q = c[5:4]; m = c[3:2]; e = c[1:0];
    return (g != w) && (w != q) && (q != m) && (m != g) &&
           (e != g) && (e != w) && (e != q) && (e != m);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    int st;
    st = sel_sym ? int'(dut_s.state) : int'(dut_f.state);
    check({tag, " busy"},      int'(m_busy),  0);
    check({tag, " done"},      int'(m_done),  0);
    check({tag, " sol_valid"}, int'(m_sv),    0);
    check({tag, " sol"},       int'(m_sol),   0);
    check({tag, " count"},     int'(m_count), 0);
    check({tag, " state"},     st,            int'(IDLE));
  endtask

  // Runs one scan on the selected instance: resets, pulses start, then
  // drives sol_ready and collects every handshake until done or abort.
  task automatic applyStimulus(input bit sym, input int ready_mode,
                               input bit pulses, input bit abort_ten,
                               output int done_cycle, output int final_count);
    bit         prev_stall;
    logic [9:0] prev_sol;
    int         stall_bad;
    int         busy_bad;
    bit         finished;
    sel_sym     = sym;
    got_q.delete();
    done_cycle  = -1;
    final_count = -1;
    prev_stall  = 1'b0;
    prev_sol    = '0;
    stall_bad   = 0;
    busy_bad    = 0;
    finished    = 1'b0;

    @(negedge clk);
    rst = 1'b1; start = 1'b0; sol_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_reset_state("reset");

    @(negedge clk);
    rst       = 1'b0;
    start     = 1'b1;
    sol_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));

    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      @(negedge clk);
      start     = 1'b0;
      sol_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (ready_mode != 0 && $urandom_range(0, 15) == 0) start = 1'b1;
      if (pulses) begin
        if (cyc == 5) start = 1'b1;
        if (cyc >= 72 && cyc <= 74) sol_ready = 1'b0;
        if (cyc == 73) start = 1'b1;
      end
      if (abort_ten && got_q.size() == 9) sol_ready = 1'b0;
      #1;

      if (pulses && cyc == 73) check("start pulse lands in HOLD", int'(m_sv), 1);
      if (!m_busy) busy_bad++;
      if (prev_stall && (!m_sv || m_sol != prev_sol)) stall_bad++;
      prev_stall = m_sv && !sol_ready;
      prev_sol   = m_sol;
      if (m_sv && sol_ready) got_q.push_back(m_sol);

      if (abort_ten && m_sv && got_q.size() == 9) begin
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1 check_reset_state("reset in HOLD");
        rst = 1'b0;
        finished = 1'b1;
        break;
      end

      if (m_done) begin
        done_cycle  = cyc;
        final_count = int'(m_count);
        @(negedge clk);
        #1;
        check("busy low after done", int'(m_busy), 0);
        check("done one cycle",      int'(m_done), 0);
        finished = 1'b1;
        break;
      end
    end

    check("scan finished within budget", int'(finished), 1);
    check("sol stable while stalled",    stall_bad, 0);
    check("busy high during scan",       busy_bad,  0);
  endtask

  // Compares a finished scan against the table entry and the model list
  task automatic checkOutput(input vec_t v, input int done_cycle,
                             input int final_count);
    logic [9:0] exp_q[$];
    int         n;
    exp_q = v.sym ? ref_sym : ref_full;
    check({v.name, " count"},      final_count,  v.exp_count);
    check({v.name, " handshakes"}, got_q.size(), v.exp_count);
    if (v.exp_done != 0) check({v.name, " done cycle"}, done_cycle, v.exp_done);
    if (got_q.size() > 0) begin
      check({v.name, " first sol"}, int'(got_q[0]), int'(v.exp_first));
      check({v.name, " last sol"},  int'(got_q[got_q.size()-1]), int'(v.exp_last));
    end
    n = (got_q.size() > exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (i >= got_q.size()) check({v.name, " missing sol"}, -1, int'(exp_q[i]));
      else if (i >= exp_q.size()) check({v.name, " extra sol"}, int'(got_q[i]), -1);
      else check($sformatf("%s sol[%0d]", v.name, i), int'(got_q[i]), int'(exp_q[i]));
    end
  endtask

  initial begin
    int dc, fc;
    rst = 1'b1; start = 1'b0; sol_ready = 1'b0; sel_sym = 1'b0;

    for (int c = 0; c < 1024; c++) begin
      logic [9:0] cv;
      cv = c[9:0];
      if (model_valid(cv)) begin
        ref_full.push_back(cv);
        if (cv[9:8] == 2'b00) ref_sym.push_back(cv);
      end
    end
    $display("[TB] model: %0d full solutions, %0d symmetric", ref_full.size(), ref_sym.size());

    vecs[0] = '{"full_ready_high",   1'b0, 0, 1'b0, 72, 1097, 10'h046, 10'h3B9};
    vecs[1] = '{"sym_ready_high",    1'b1, 0, 1'b0, 18, 275,  10'h046, 10'h0ED};
    vecs[2] = '{"full_backpressure", 1'b0, 1, 1'b0, 72, 0,    10'h046, 10'h3B9};
    vecs[3] = '{"full_start_pulses", 1'b0, 0, 1'b1, 72, 1100, 10'h046, 10'h3B9};
    vecs[4] = '{"sym_backpressure",  1'b1, 1, 1'b0, 18, 0,    10'h046, 10'h0ED};

    for (int i = 0; i < 5; i++) begin
      $display("[TB] scenario %s", vecs[i].name);
      applyStimulus(vecs[i].sym, vecs[i].ready_mode, vecs[i].pulses, 1'b0, dc, fc);
      checkOutput(vecs[i], dc, fc);
    end

    $display("[TB] scenario reset_in_hold");
    applyStimulus(1'b0, 0, 1'b0, 1'b1, dc, fc);
    check("reset_in_hold collected", got_q.size(), 9);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, dc, fc);
    checkOutput(vecs[0], dc, fc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/map_color_search.md
# map_color_search

Sequential enumerator that sits directly upstream of the Land of Oz four-color validity checker. On `start`, it walks every candidate coloring of the five regions (GC, WC, QC, MC, EC), one per clock, and evaluates each through the combinational adjacency check. It streams each valid coloring out over a valid/ready handshake and reports the total solution count when the scan finishes. It is the search front-end that turns the checker into a complete solver.

## Interface
- `SKIP_SYMMETRIC`, default 0. When 1, GC is fixed to color 0, which cuts the search from 1024 to 256 candidates and the solutions from 72 to 18.
- `clk` in 1. Single clock; all state changes on the rising edge.
- `rst` in 1. Reset is synchronous and active-high.
- `start` in 1. Single-cycle request to begin a scan; ignored while `busy`.
- `busy` out 1. High from the cycle after `start` is accepted until the `done` cycle, inclusive.
- `done` out 1. One-cycle pulse at the end of a scan.
- `sol_valid` out 1. A valid coloring is presented on `sol`.
- `sol_ready` in 1. Consumer accepts `sol` when `sol_valid && sol_ready`.
- `sol` out 10. Packed coloring {GC[9:8], WC[7:6], QC[5:4], MC[3:2], EC[1:0]}.
- `count` out 11. Number of valid colorings found in the current or last scan.

## Operation
- The candidate counter `cand` is 10 bits, with EC in the LSBs; it increments by 1 from 0.
  - When `SKIP_SYMMETRIC`=1, only `cand[7:0]` counts and GC is forced to 00.
  - The last candidate is 0x3FF, or 0x0FF when symmetric.
- A candidate is valid iff all eight adjacency pairs differ: GC/WC, WC/QC, QC/MC, MC/GC, and EC against each of GC, WC, QC, MC.
- FSM states:
  - IDLE: on `start`, clear `cand` and `count`, then go to SCAN.
  - SCAN: evaluate `cand`.
    - If valid: register it into `sol`, set `sol_valid`, increment `count`, go to HOLD.
    - Else, if `cand` is last: go to DONE.
    - Else: increment `cand` and stay in SCAN.
  - HOLD: keep `sol` and `sol_valid` stable until `sol_ready`.
    - On handshake: drop `sol_valid`. If `cand` is last go to DONE, else increment `cand` and go to SCAN.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- `count` holds its value in IDLE until the next accepted `start`.
- `sol` holds the last solution after the handshake; its value is don't-care when `sol_valid`=0, but it must not glitch while `sol_valid`=1.
- `start` in any state other than IDLE has no effect.
- `rst` at any time, including mid-scan or mid-HOLD:
  - FSM goes to IDLE.
  - `busy`, `done`, `sol_valid` go to 0.
  - `sol` goes to 0 and `count` goes to 0.
  - Any pending solution is discarded.

## Timing
- Reset values: every output is 0.
- Throughput: one candidate per cycle in SCAN. Each solution costs at least one HOLD cycle, plus one cycle for each cycle that `sol_ready` is low.
- `sol_valid` rises in the cycle after the SCAN cycle that found the solution. It may fall and rise again no sooner than two cycles later.
- With `sol_ready` tied high, if `start` is sampled at edge 0, `done` is high in cycle:
  - 1097 (1 + 1024 + 72) when `SKIP_SYMMETRIC`=0;
  - 275 (1 + 256 + 18) when `SKIP_SYMMETRIC`=1.
- `count` is final when `done` is high.
- Backpressure on `sol_ready` stalls the scan indefinitely with no loss or duplication of solutions.

## Structure
- Shared package holds:
  - the field offsets of `sol`;
  - the FSM state enum {IDLE, SCAN, HOLD, DONE};
  - the constants NUM_CAND_FULL=1024, NUM_CAND_SYM=256, NUM_SOL_FULL=72, NUM_SOL_SYM=18.
- One sub-module, `oz_adjacency_check`: purely combinational, takes five 2-bit colors and returns `valid`, with no state. The top-level contains only the counter, the FSM, the output registers, and `count`.

## Test plan
- Reset, then `start` with `sol_ready`=1 and `SKIP_SYMMETRIC`=0:
  - first `sol` = 0x046 (GC0 WC1 QC0 MC1 EC2);
  - last `sol` = 0x3B9 (GC3 WC2 QC3 MC2 EC1);
  - 72 handshakes total, `count`=72, `done` in cycle 1097.
- Same run with `SKIP_SYMMETRIC`=1: 18 handshakes, every `sol[9:8]`=00, `count`=18, `done` in cycle 275.
- Random `sol_ready` backpressure (50% low): the same 72 solutions appear in strictly increasing order, with no duplicates, and `sol` is stable while `sol_valid` && !`sol_ready`.
- `start` pulsed during SCAN and again during HOLD: no restart, and the results are identical to the first scenario.
- `rst` asserted while in HOLD on the 10th solution: next cycle all outputs are 0 and the FSM is in IDLE. A new `start` then reproduces the full 72-solution scan from 0x046.
- A scoreboard checks every emitted `sol` against a reference model of the eight inequalities, and checks that no candidate rejected by the model is emitted.
